// File: rtl/serial_hex_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package serial_hex_add_ctrl_pkg;

    localparam int unsigned NibbleW        = 4;
    localparam int unsigned DefaultNibbles = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/hex_adder_4.sv
// 4-bit ripple-carry adder shared by every nibble step of the serial controller.
module hex_adder_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic c;

    always_comb begin
        sum = '0;
        c   = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/serial_hex_add_ctrl.sv
// Nibble-serial add/subtract: one shared 4-bit adder walks the operands LSB nibble first,
// with a valid/ready handshake on both the request and the result side.
module serial_hex_add_ctrl
    import serial_hex_add_ctrl_pkg::*;
#(
    parameter int unsigned NIBBLES = DefaultNibbles
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NibbleW*NIBBLES-1:0]   op_a,
    input  logic [NibbleW*NIBBLES-1:0]   op_b,
    input  logic                         sub,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NibbleW*NIBBLES-1:0]   result,
    output logic                         cout,
    output logic                         ovf
);

    localparam int unsigned W    = NibbleW * NIBBLES;
    localparam int unsigned IdxW = $clog2(NIBBLES);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic            carry_q, carry_d;
    logic [IdxW-1:0] nib_idx_q, nib_idx_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [NibbleW-1:0] add_sum;
    logic               add_cout;

    // Operands shift right each step, so the adder always sees the low nibble.
    hex_adder_4 u_adder (
        .a    (a_q[NibbleW-1:0]),
        .b    (b_q[NibbleW-1:0]),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        carry_d   = carry_q;
        nib_idx_d = nib_idx_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d       = op_a;
                    b_d       = sub ? ~op_b : op_b;
                    carry_d   = sub;
                    nib_idx_d = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                a_d       = {{NibbleW{1'b0}}, a_q[W-1:NibbleW]};
                b_d       = {{NibbleW{1'b0}}, b_q[W-1:NibbleW]};
                res_d     = {add_sum, res_q[W-1:NibbleW]};
                carry_d   = add_cout;
                nib_idx_d = nib_idx_q + 1'b1;
                if (nib_idx_q == LastIdx) begin
                    // Low nibbles of a_q/b_q hold the operand MSBs on the final step.
                    cout_d  = add_cout;
                    ovf_d   = (a_q[NibbleW-1] == b_q[NibbleW-1]) &&
                              (add_sum[NibbleW-1] != a_q[NibbleW-1]);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            nib_idx_q <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            carry_q   <= carry_d;
            nib_idx_q <= nib_idx_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = res_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_hex_add_ctrl.sv
// Scoreboard bench: driver pushes arithmetic-model expectations, monitor checks each result.
module tb_serial_hex_add_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    logic prev_valid = 1'b0;
    logic prev_hs = 1'b0;

    serial_hex_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Plain-integer reference: modular sum/difference, unsigned carry, signed range overflow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t   e;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint m  = longint'(1) << W;
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sbv = (ub >= m / 2) ? ub - m : ub;
        longint full, sres;
        if (!s) begin
            full = ua + ub;
            e.c  = (full >= m);
            sres = sa + sbv;
        end else begin
            full = ua - ub + m;
            e.c  = (ua >= ub);
            sres = sa - sbv;
        end
        e.res = W'(full % m);
        e.v   = (sres >= m / 2) || (sres < -(m / 2));
        e.acc = 0;
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        sub      = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = W'($urandom);
        op_b     = W'($urandom);
        sub      = 1'($urandom);
        e        = model(a, b, s);
        e.acc    = cyc;
        sb.push_back(e);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int hold, input bit noise);
        int n = 0;
        issue(a, b, s);
        if (noise) begin
            repeat (2) begin
                in_valid = 1'b1;
                op_a     = W'($urandom);
                op_b     = W'($urandom);
                sub      = 1'($urandom);
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
        end
        out_ready = (hold == 0);
        while (!out_valid && n < NIBBLES + 4) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("out_valid_timeout", {63'd0, out_valid}, 64'd1);
        if (!out_valid) begin
            sb.delete();
            out_ready = 1'b0;
            return;
        end
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_hs) begin
                chk("valid_after_consume", {63'd0, out_valid}, 64'd0);
                chk("ready_after_consume", {63'd0, in_ready}, 64'd1);
            end
            if (out_valid) begin
                chk("in_ready_while_valid", {63'd0, in_ready}, 64'd0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got %0h with no pending operation", result);
                end else begin
                    if (!prev_valid) chk("latency", 64'(cyc - sb[0].acc), 64'(NIBBLES));
                    chk("result", 64'(result), 64'(sb[0].res));
                    chk("cout", {63'd0, cout}, {63'd0, sb[0].c});
                    chk("ovf", {63'd0, ovf}, {63'd0, sb[0].v});
                    if (out_ready) void'(sb.pop_front());
                end
            end
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_result"}, 64'(result), 64'd0);
        chk({tag, "_cout"}, {63'd0, cout}, 64'd0);
        chk({tag, "_ovf"}, {63'd0, ovf}, 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b0;

        run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 2, 1'b0);
        run_op(16'hA5A5, 16'h1111, 1'b0, 3, 1'b0);
        run_op(16'h0F0F, 16'h0101, 1'b0, 0, 1'b0);
        run_op(16'h2222, 16'h3333, 1'b1, 0, 1'b1);

        // Reset in the 2nd RUN cycle, with a competing in_valid that must lose.
        issue(16'h1357, 16'h2468, 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        op_a     = 16'h0101;
        op_b     = 16'h0202;
        sb.delete();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk_reset_state("midrun_reset");
        repeat (NIBBLES + 3) @(posedge clk);
        #1;
        chk("no_stale_valid", {63'd0, out_valid}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 8 == 0) ra = 16'h8000;
            if (i % 8 == 4) rb = 16'hFFFF;
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/serial_hex_add_ctrl.md
SERIAL_HEX_ADD_CTRL -- requirements
Module: serial_hex_add_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4: operand width in 4-bit nibbles; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  requester presents an operation.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 op_a  input  4*NIBBLES  operand A.
REQ-007 op_b  input  4*NIBBLES  operand B.
REQ-008 sub  input  1  0 = A+B, 1 = A-B.
REQ-009 out_valid  output  1  result fields are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  4*NIBBLES  sum or difference, modulo 2^(4*NIBBLES).
REQ-012 cout  output  1  carry out of the top nibble; for subtract, 1 = no borrow.
REQ-013 ovf  output  1  two's-complement signed overflow.

Function
REQ-014 The block SHALL sequence one shared 4-bit adder over the operands, one nibble per cycle, LSB nibble first.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-017 On an edge with in_valid=1 in IDLE, the block SHALL capture op_a, the effective B (op_b, or ~op_b when sub=1) and sub; it SHALL then clear nib_idx and go to RUN.
REQ-018 The initial carry SHALL be sub: 0 for add, 1 for subtract.
REQ-019 In each RUN cycle the adder SHALL add nibble[nib_idx] of A, nibble[nib_idx] of effective B and the carry register.
REQ-020 At the end of each RUN cycle, the 4-bit sum SHALL be written to result nibble[nib_idx], the adder carry-out SHALL be written to the carry register, and nib_idx SHALL increment.
REQ-021 When nib_idx=NIBBLES-1 completes, the FSM SHALL go to DONE, out_valid SHALL become 1 and cout SHALL equal the final carry.
REQ-022 Latency: out_valid SHALL rise exactly NIBBLES rising edges after the accepting edge (4 for the default).
REQ-023 ovf SHALL be 1 exactly when MSB(A)==MSB(effective B) and MSB(result)!=MSB(A); it SHALL be registered with the result.
REQ-024 In DONE, out_valid, result, cout and ovf SHALL hold stable until the first edge with out_ready=1, after which the FSM SHALL return to IDLE.
REQ-025 After that edge, out_valid SHALL be 0.
REQ-026 in_valid and operand changes while in RUN or DONE SHALL be ignored and SHALL NOT corrupt the operation in flight.
REQ-027 A new operation SHALL NOT be accepted in the same cycle that a result is consumed; the minimum issue interval is NIBBLES+2 cycles.
REQ-028 The values of result, cout and ovf SHALL be don't-care while out_valid=0, except where REQ-030 fixes them.

Reset
REQ-029 On any edge with rst=1, regardless of state (including mid-RUN or DONE), the FSM SHALL go to IDLE and the in-flight operation SHALL be discarded.
REQ-030 The reset values SHALL be: in_ready=1 in the first cycle after reset, out_valid=0, result=0, cout=0, ovf=0, nib_idx=0, carry register=0.
REQ-031 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE), the nibble width constant 4, and the default NIBBLES value.
REQ-033 The 4-bit ripple adder SHALL be a single instantiated sub-module named hex_adder_4, with ports a[3:0], b[3:0], cin, sum[3:0] and cout.
REQ-034 serial_hex_add_ctrl SHALL contain only the FSM, the operand and result shift/index registers, and the carry register; it SHALL NOT perform arithmetic inline.

Verification
REQ-035 Add 0x1234+0x4321, sub=0 -> out_valid 4 cycles after accept; result=0x5555, cout=0, ovf=0.
REQ-036 Add 0xFFFF+0x0001 -> result=0x0000, cout=1, ovf=0; add 0x7FFF+0x0001 -> result=0x8000, cout=0, ovf=1.
REQ-037 Subtract 0x0005-0x0007 -> result=0xFFFE, cout=0, ovf=0; subtract 0x8000-0x0001 -> result=0x7FFF, cout=1, ovf=1.
REQ-038 Backpressure: complete an add with out_ready=0 for 3 cycles -> out_valid, result, cout and ovf are stable and in_ready=0 throughout.
REQ-038 (cont.) Raising out_ready -> IDLE on the next edge, then a new operation is accepted.
REQ-039 Apply in_valid with different operands during RUN -> ignored; the original result is delivered.
REQ-039 (cont.) Assert rst during the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, result=0, and no stale result appears later.
